// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: forwarding, load-use/branch stall-flush, data-memory wait/timeout FSM.
// Latency 0 for all controls (comb); mem wait states freeze the pipe; define HAZARD_PERF_EN for perf counters.
// Backpressure: i_mem_ready low holds all stage registers until ready or timeout error.
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int PERF_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [4:0]        i_rs1_ID,
  input  logic [4:0]        i_rs2_ID,
  input  logic [4:0]        i_rs1_EX,
  input  logic [4:0]        i_rs2_EX,
  input  logic [4:0]        i_addr_des_EX,
  input  logic [1:0]        i_result_src_EX,
  input  logic              i_pc_src_EX,
  input  logic [4:0]        i_addr_des_MEM,
  input  logic              i_reg_write_MEM,
  input  logic              i_mem_access_MEM,
  input  logic              i_mem_ready,
  input  logic [4:0]        i_addr_des_WB,
  input  logic              i_reg_write_WB,
  input  logic              i_perf_clr,
  output logic              o_stall_IF,
  output logic              o_stall_ID,
  output logic              o_stall_EX,
  output logic              o_stall_MEM,
  output logic              o_flush_ID,
  output logic              o_flush_EX,
  output logic              o_flush_WB,
  output logic [1:0]        o_forward_a_EX,
  output logic [1:0]        o_forward_b_EX,
  output logic              o_mem_req,
  output logic              o_mem_err,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_stall;
  logic             mem_req;
  logic             lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (i_reg_write_MEM && (i_addr_des_MEM != 5'd0) && (i_addr_des_MEM == rs))
      return 2'b10;
    else if (i_reg_write_WB && (i_addr_des_WB != 5'd0) && (i_addr_des_WB == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lw_stall = (i_result_src_EX == 2'b01) && (i_addr_des_EX != 5'd0) &&
                    ((i_addr_des_EX == i_rs1_ID) || (i_addr_des_EX == i_rs2_ID));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_req = i_mem_access_MEM;
        if (i_mem_access_MEM && !i_mem_ready) begin
          mem_stall = 1'b1;
          state_d   = S_WAIT;
          cnt_d     = CNT_W'(1);
        end
      end
      S_WAIT: begin
        mem_req = 1'b1;
        if (i_mem_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          mem_stall = 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_ERR;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_mem_err = (state_q == S_ERR);

  // Memory stall wins so a frozen pipe never loses a branch or load-use event; both re-evaluate on release.
  always_comb begin
    o_stall_IF     = 1'b0;
    o_stall_ID     = 1'b0;
    o_stall_EX     = 1'b0;
    o_stall_MEM    = 1'b0;
    o_flush_ID     = 1'b0;
    o_flush_EX     = 1'b0;
    o_flush_WB     = 1'b0;
    o_forward_a_EX = 2'b00;
    o_forward_b_EX = 2'b00;
    o_mem_req      = 1'b0;
    if (i_rst_n) begin
      o_forward_a_EX = fwd_sel(i_rs1_EX);
      o_forward_b_EX = fwd_sel(i_rs2_EX);
      o_mem_req      = mem_req;
      if (mem_stall) begin
        o_stall_IF  = 1'b1;
        o_stall_ID  = 1'b1;
        o_stall_EX  = 1'b1;
        o_stall_MEM = 1'b1;
        o_flush_WB  = 1'b1;
      end else if (i_pc_src_EX) begin
        o_flush_ID = 1'b1;
        o_flush_EX = 1'b1;
      end else if (lw_stall) begin
        o_stall_IF = 1'b1;
        o_stall_ID = 1'b1;
        o_flush_EX = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (i_perf_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_stall_IF && (stall_cnt_q != {PERF_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (o_flush_EX && (flush_cnt_q != {PERF_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = i_perf_clr;
  assign o_stall_cnt     = '0;
  assign o_flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl (works with or without HAZARD_PERF_EN).
module tb_hazard_ctrl;

  localparam int PERF_W = 32;
`ifdef HAZARD_PERF_EN
  localparam int EXP_STALL_CNT = 5;
  localparam int EXP_FLUSH_CNT = 2;
`else
  localparam int EXP_STALL_CNT = 0;
  localparam int EXP_FLUSH_CNT = 0;
`endif

  // Observed word: {stall IF,ID,EX,MEM, flush ID,EX,WB, fwd_a, fwd_b, req}
  localparam logic [11:0] W_IDLE   = 12'b0000_000_00_00_0;
  localparam logic [11:0] W_LW     = 12'b1100_010_00_00_0;
  localparam logic [11:0] W_BR     = 12'b0000_110_00_00_0;
  localparam logic [11:0] W_MSTALL = 12'b1111_001_00_00_1;
  localparam logic [11:0] W_ERR    = 12'b1111_001_00_00_0;
  localparam logic [11:0] W_REQ    = 12'b0000_000_00_00_1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic [1:0] res_src;
  logic pc_src, rw_mem, rw_wb, mem_access, mem_ready, perf_clr;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb;
  logic [1:0] fwd_a, fwd_b;
  logic mem_req, mem_err;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;
  logic [11:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT_CYCLES(16), .PERF_W(PERF_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_ID(rs1_id), .i_rs2_ID(rs2_id), .i_rs1_EX(rs1_ex), .i_rs2_EX(rs2_ex),
    .i_addr_des_EX(rd_ex), .i_result_src_EX(res_src), .i_pc_src_EX(pc_src),
    .i_addr_des_MEM(rd_mem), .i_reg_write_MEM(rw_mem), .i_mem_access_MEM(mem_access),
    .i_mem_ready(mem_ready), .i_addr_des_WB(rd_wb), .i_reg_write_WB(rw_wb),
    .i_perf_clr(perf_clr),
    .o_stall_IF(stall_if), .o_stall_ID(stall_id), .o_stall_EX(stall_ex), .o_stall_MEM(stall_mem),
    .o_flush_ID(flush_id), .o_flush_EX(flush_ex), .o_flush_WB(flush_wb),
    .o_forward_a_EX(fwd_a), .o_forward_b_EX(fwd_b),
    .o_mem_req(mem_req), .o_mem_err(mem_err),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  assign obs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb,
                fwd_a, fwd_b, mem_req};

  typedef struct {
    logic [4:0]  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex;
    logic [1:0]  res_src;
    logic        pc_src;
    logic [4:0]  rd_mem;
    logic        rw_mem;
    logic [4:0]  rd_wb;
    logic        rw_wb;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input int a_rs1_id, input int a_rs2_id, input int a_rs1_ex,
                              input int a_rs2_ex, input int a_rd_ex, input int a_res,
                              input int a_pc, input int a_rd_mem, input int a_rw_mem,
                              input int a_rd_wb, input int a_rw_wb, input logic [11:0] a_exp);
    vec_t v;
    v.rs1_id  = 5'(a_rs1_id);
    v.rs2_id  = 5'(a_rs2_id);
    v.rs1_ex  = 5'(a_rs1_ex);
    v.rs2_ex  = 5'(a_rs2_ex);
    v.rd_ex   = 5'(a_rd_ex);
    v.res_src = 2'(a_res);
    v.pc_src  = 1'(a_pc);
    v.rd_mem  = 5'(a_rd_mem);
    v.rw_mem  = 1'(a_rw_mem);
    v.rd_wb   = 5'(a_rd_wb);
    v.rw_wb   = 1'(a_rw_wb);
    v.exp     = a_exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; res_src = 0; pc_src = 0;
    rd_mem = 0; rw_mem = 0; rd_wb = 0; rw_wb = 0; mem_access = 0; mem_ready = 0; perf_clr = 0;
  endtask

  task automatic apply(input vec_t v);
    rs1_id = v.rs1_id; rs2_id = v.rs2_id; rs1_ex = v.rs1_ex; rs2_ex = v.rs2_ex;
    rd_ex = v.rd_ex; res_src = v.res_src; pc_src = v.pc_src;
    rd_mem = v.rd_mem; rw_mem = v.rw_mem; rd_wb = v.rd_wb; rw_wb = v.rw_wb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Access with three wait cycles; a branch + load-use arrives mid-wait and must be suppressed.
  task automatic mem_wait3();
    next_cycle(); clr_in(); mem_access = 1; mem_ready = 0;
    sample(); chk("mw_c0", 32'(obs), 32'(W_MSTALL));
    next_cycle(); pc_src = 1; res_src = 2'b01; rd_ex = 7; rs2_id = 7;
    sample(); chk("mw_c1_override", 32'(obs), 32'(W_MSTALL));
    next_cycle(); pc_src = 0; res_src = 0; rd_ex = 0; rs2_id = 0;
    sample(); chk("mw_c2", 32'(obs), 32'(W_MSTALL));
    next_cycle(); mem_ready = 1;
    sample(); chk("mw_ready", 32'(obs), 32'(W_REQ));
    next_cycle(); mem_access = 0; mem_ready = 0;
    sample(); chk("mw_idle_after", 32'(obs), 32'(W_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_stall;
    bit err_seen;

    vecs[0]  = mk(0,0,0,0,0,0,0, 0,0, 0,0, W_IDLE);
    vecs[1]  = mk(0,0,5,0,0,0,0, 5,1, 0,0, 12'b0000_000_10_00_0);
    vecs[2]  = mk(0,0,5,0,0,0,0, 5,1, 5,1, 12'b0000_000_10_00_0);
    vecs[3]  = mk(0,0,5,5,0,0,0, 0,0, 5,1, 12'b0000_000_01_01_0);
    vecs[4]  = mk(0,0,0,0,0,0,0, 0,0, 0,1, W_IDLE);
    vecs[5]  = mk(0,0,0,3,0,0,0, 3,0, 3,1, 12'b0000_000_00_01_0);
    vecs[6]  = mk(0,0,0,0,0,0,0, 0,1, 0,0, W_IDLE);
    vecs[7]  = mk(0,7,0,0,7,1,0, 0,0, 0,0, W_LW);
    vecs[8]  = mk(7,0,0,0,7,1,0, 0,0, 0,0, W_LW);
    vecs[9]  = mk(0,0,0,0,0,1,0, 0,0, 0,0, W_IDLE);
    vecs[10] = mk(7,0,0,0,7,0,0, 0,0, 0,0, W_IDLE);
    vecs[11] = mk(7,0,0,0,7,2,0, 0,0, 0,0, W_IDLE);
    vecs[12] = mk(0,7,0,0,7,1,1, 0,0, 0,0, W_BR);
    vecs[13] = mk(0,0,0,0,0,0,1, 0,0, 0,0, W_BR);
    vecs[14] = mk(9,0,2,4,9,1,0, 2,1, 4,1, 12'b1100_010_10_01_0);
    vecs[15] = mk(0,0,6,8,0,0,0, 6,1, 8,0, 12'b0000_000_10_00_0);
    vecs[16] = mk(8,9,0,0,7,1,0, 0,0, 0,0, W_IDLE);

    // Reset: hazard-provoking inputs must not leak through while reset is low
    clr_in();
    rst_n = 0;
    mem_access = 1; rd_mem = 5; rw_mem = 1; rs1_ex = 5; pc_src = 1;
    res_src = 2'b01; rd_ex = 3; rs1_id = 3;
    #12;
    chk("reset_outputs", 32'(obs), 32'(W_IDLE));
    chk("reset_err", 32'(mem_err), 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
    clr_in();
    #1 rst_n = 1;

    foreach (vecs[i]) begin
      next_cycle();
      apply(vecs[i]);
      sample();
      chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
    end

    // Load-use lasts one cycle: lw moves to MEM, bubble in EX, consumer now forwards from MEM
    next_cycle(); clr_in(); res_src = 2'b01; rd_ex = 7; rs2_id = 7;
    sample(); chk("lu_cycle0", 32'(obs), 32'(W_LW));
    next_cycle(); clr_in(); rd_mem = 7; rw_mem = 1; rs2_ex = 7;
    sample(); chk("lu_cycle1", 32'(obs), 32'(12'b0000_000_00_10_0));

    mem_wait3();

    // Zero-wait access
    next_cycle(); clr_in(); mem_access = 1; mem_ready = 1;
    sample(); chk("zero_wait", 32'(obs), 32'(W_REQ));
    next_cycle(); clr_in();
    sample(); chk("zero_wait_after", 32'(obs), 32'(W_IDLE));

    // Reset asserted while waiting drops the request immediately
    next_cycle(); mem_access = 1; mem_ready = 0;
    sample(); chk("rstwait_c0", 32'(obs), 32'(W_MSTALL));
    next_cycle();
    rst_n = 0;
    #1 chk("rstwait_req_drop", 32'(obs), 32'(W_IDLE));
    clr_in();
    rst_n = 1;
    sample(); chk("rstwait_idle", 32'(obs), 32'(W_IDLE));

    // Timeout: ready held low
    next_cycle(); clr_in(); mem_access = 1; mem_ready = 0;
    n_stall = 0;
    err_seen = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (mem_err) begin
        err_seen = 1;
        break;
      end
      if (stall_if) n_stall++;
      next_cycle();
    end
    chk("timeout_err_seen", 32'(err_seen), 32'd1);
    chk("timeout_stall_cycles", 32'(n_stall), 32'd16);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); mem_ready = (i == 1);
      sample();
      chk($sformatf("err_sticky%0d", i), 32'({mem_err, obs}), 32'({1'b1, W_ERR}));
    end
    #2 rst_n = 0;
    #2 chk("err_reset_clear", 32'({mem_err, obs}), 32'({1'b0, W_IDLE}));
    clr_in();
    #2 rst_n = 1;
    next_cycle();
    sample(); chk("after_err_reset", 32'({mem_err, obs}), 32'({1'b0, W_IDLE}));

    // Perf counters: clear, 2 load-use stalls, 3 wait cycles
    next_cycle(); clr_in(); perf_clr = 1;
    next_cycle(); clr_in();
    sample(); chk("perf_cleared_stall", stall_cnt, 32'd0);
    for (int k = 0; k < 2; k++) begin
      next_cycle(); clr_in(); res_src = 2'b01; rd_ex = 4; rs1_id = 4;
      next_cycle(); clr_in();
    end
    mem_wait3();
    next_cycle(); clr_in();
    sample();
    chk("perf_stall_cnt", stall_cnt, 32'(EXP_STALL_CNT));
    chk("perf_flush_cnt", flush_cnt, 32'(EXP_FLUSH_CNT));
    // Clear beats a simultaneous load-use increment
    next_cycle(); perf_clr = 1; res_src = 2'b01; rd_ex = 4; rs1_id = 4;
    next_cycle(); clr_in();
    sample();
    chk("perf_clr_stall", stall_cnt, 32'd0);
    chk("perf_clr_flush", flush_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
